// File: rtl/audio_clk_pkg.sv
// rtl/audio_clk_pkg.sv - audio PLL supervisor states, default cycle budgets and retry width
package audio_clk_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } pll_state_e;

  // Defaults assume a 50 MHz refclk.
  localparam int unsigned DEF_RST_PULSE_CYC    = 50;
  localparam int unsigned DEF_LOCK_STABLE_CYC  = 5000;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 500000;
  localparam int unsigned DEF_MAX_RETRIES      = 3;
  localparam int unsigned DEF_CNT_W            = 20;
  localparam int unsigned RETRY_W              = 2;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchroniser, async active-low reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/audio_pll_supervisor.sv
// rtl/audio_pll_supervisor.sv - sequences the audio PLL reset, qualifies lock, gates the MCLK-domain reset
module audio_pll_supervisor
  import audio_clk_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned MAX_RETRIES      = DEF_MAX_RETRIES,
  parameter int unsigned CNT_W            = DEF_CNT_W
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked_i,
  input  logic               relock_req_i,
  output logic               pll_rst_o,
  output logic               audio_rst_n_o,
  output logic               clk_ready_o,
  output logic               fault_o,
  output logic               lost_lock_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic               audio_rst_n_q, audio_rst_n_d;
  logic               clk_ready_q, clk_ready_d;
  logic               fault_q, fault_d;
  logic               lost_lock_q, lost_lock_d;
  logic               lock_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    retry_d     = retry_q;
    lost_lock_d = 1'b0;

    if (relock_req_i) begin
      state_d = RESET_PLL;
      retry_d = '0;
    end else begin
      case (state_q)
        RESET_PLL: if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (cnt_q == TMO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = RESET_PLL;
              retry_d = retry_q + RETRY_W'(1);
            end
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_d = WAIT_LOCK;
          end else if (cnt_q == STB_LAST) begin
            state_d = RUN;
            retry_d = '0;
          end
        end
        RUN: begin
          cnt_d = cnt_q;
          if (!lock_s) begin
            state_d     = RESET_PLL;
            lost_lock_d = 1'b1;
          end
        end
        FAULT:   cnt_d = cnt_q;
        default: state_d = RESET_PLL;
      endcase
    end

    // Every state entry (including a relock into RESET_PLL) restarts the count.
    if ((state_d != state_q) || relock_req_i) cnt_d = '0;

    pll_rst_d     = (state_d == RESET_PLL) || (state_d == FAULT);
    audio_rst_n_d = (state_d == RUN);
    clk_ready_d   = (state_d == RUN);
    fault_d       = (state_d == FAULT);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      retry_q       <= '0;
      pll_rst_q     <= 1'b1;
      audio_rst_n_q <= 1'b0;
      clk_ready_q   <= 1'b0;
      fault_q       <= 1'b0;
      lost_lock_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pll_rst_q     <= pll_rst_d;
      audio_rst_n_q <= audio_rst_n_d;
      clk_ready_q   <= clk_ready_d;
      fault_q       <= fault_d;
      lost_lock_q   <= lost_lock_d;
    end
  end

  assign pll_rst_o     = pll_rst_q;
  assign audio_rst_n_o = audio_rst_n_q;
  assign clk_ready_o   = clk_ready_q;
  assign fault_o       = fault_q;
  assign lost_lock_o   = lost_lock_q;
  assign retry_cnt_o   = retry_q;

endmodule
